riscv_ctrl_fsm: RTL and testbench
=================================

Name: riscv_ctrl_fsm

Overview:
Multi-cycle control FSM for the RV32I core. It drives the ENA inputs of the PC, IR and MDR register instances, plus the register-file write enable, memory request and datapath mux selects. It sits directly upstream of the n-bit register stages: every register load in the datapath is gated by this block. It also owns the memory-wait watchdog and a retired-instruction counter.

Parameters:
WAIT_LIMIT, 15, consecutive MEM_READY-low cycles in FETCH or MEM before the FSM enters FAULT (must be ≥1)
CNT_W, 32, width of the INSTRET counter

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
OPCODE  in  7  IR[6:0], stable from DECODE onward
FUNCT3  in  3  IR[14:12]
FUNCT7_5  in  1  IR[30]
BR_TAKEN  in  1  branch comparator result, valid in EXEC
MEM_READY  in  1  memory completes the current request this cycle
PC_ENA  out  1  PC register load enable
IR_ENA  out  1  IR register load enable
MDR_ENA  out  1  MDR register load enable
RF_WE  out  1  register-file write enable
MEM_REQ  out  1  memory request
MEM_WE  out  1  memory write (qualifies MEM_REQ)
PC_SEL  out  2  0=PC+4, 1=PC+imm, 2=ALU result
ALU_A_SEL  out  2  0=rs1, 1=PC, 2=zero
ALU_B_SEL  out  2  0=rs2, 1=imm
ALU_OP  out  4  {f7_5_eff, funct3}: ADD=0000, SUB=1000, SRA=1101, others f3 with bit3=0
WB_SEL  out  2  0=ALU, 1=MDR, 2=PC+4
STATE  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=7
FAULT  out  1  sticky fault flag
INSTRET  out  CNT_W  retired-instruction count

Behaviour:
- Reset (RST low): STATE=FETCH, wait counter=0, INSTRET=0, FAULT=0.
- Reset gating: while RST is low, every enable/request output is forced to 0 combinationally. All selects are 0.
- Output style: outputs are combinational from state, decoded opcode and the MEM_READY/BR_TAKEN inputs. State, counter and INSTRET are registered.
- FETCH:
  - MEM_REQ=1, MEM_WE=0.
  - On MEM_READY: IR_ENA=1, go to DECODE.
- DECODE: no enables asserted.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 0110111, 0010111, 1101111, 1100111, 1100011. A legal opcode goes to EXEC.
  - Any other opcode goes to FAULT.
- EXEC / MEM / WB hold the ALU selects constant for the whole instruction:
  - R-type: A=rs1, B=rs2, op={F7_5, F3}.
  - OP-IMM: A=rs1, B=imm, op={F3==101 ? F7_5 : 0, F3}.
  - LOAD, STORE, JALR: A=rs1, B=imm, ADD.
  - LUI: A=zero, B=imm, ADD. AUIPC: A=PC, B=imm, ADD.
  - In FETCH and DECODE all selects are 0.
- EXEC:
  - BRANCH retires here: PC_ENA=1, PC_SEL=BR_TAKEN ? 1 : 0, next state FETCH.
  - LOAD and STORE go to MEM. All other legal opcodes go to WB.
- MEM:
  - MEM_REQ=1, MEM_WE=1 for STORE only.
  - On MEM_READY, LOAD: MDR_ENA=1, go to WB.
  - On MEM_READY, STORE: PC_ENA=1, PC_SEL=0, retire, go to FETCH.
- WB: RF_WE=1, PC_ENA=1, retire, go to FETCH.
  - WB_SEL: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - PC_SEL: 1 for JAL, 2 for JALR, 0 otherwise.
- Retirement: INSTRET increments by 1 in every cycle where PC_ENA=1. It wraps modulo 2^CNT_W.
- Watchdog:
  - The wait counter clears on entry to FETCH or MEM.
  - Each cycle in FETCH/MEM with MEM_READY=0: if counter==WAIT_LIMIT-1, go to FAULT; otherwise increment.
  - MEM_READY=1 in the limit cycle wins, so no fault is raised.
- FAULT: FAULT=1, all enables 0, selects 0. Only RST exits FAULT.
- Reset mid-instruction: abandons it immediately with no retirement. After release the FSM restarts at FETCH.

Decomposition:
- Shared package riscv_ctrl_pkg:
  - state enum with the codes above
  - opcode constants
  - PC_SEL, ALU_A_SEL, ALU_B_SEL and WB_SEL encodings
  - ALU_OP codes
- One combinational sub-module, riscv_alu_decode: maps OPCODE/FUNCT3/FUNCT7_5 to ALU_OP, ALU_A_SEL, ALU_B_SEL and the legal flag.
- The FSM, watchdog and INSTRET stay in riscv_ctrl_fsm.

Test Plan:
- SUB (OPCODE 0110011, F3=000, F7_5=1), MEM_READY=1 throughout:
  - STATE sequence 0,1,2,4,0; IR_ENA in cycle 0.
  - ALU_OP=1000 in EXEC and WB; RF_WE=1, PC_ENA=1, PC_SEL=0 in WB.
  - INSTRET=1 after 4 cycles.
- LOAD with MEM_READY low for 3 MEM cycles:
  - MEM_REQ=1, MEM_WE=0 for 4 MEM cycles; MDR_ENA only in the 4th.
  - WB_SEL=1 in WB; 8 cycles total, INSTRET+1.
- BEQ (1100011):
  - BR_TAKEN=1: PC_ENA=1, PC_SEL=1 in EXEC, RF_WE never 1, 3 cycles.
  - BR_TAKEN=0: PC_SEL=0.
- FETCH with MEM_READY=0 for 15 cycles:
  - FAULT=1 and STATE=7 after the 15th edge; all enables 0 thereafter.
  - MEM_READY=1 on cycle 15 instead gives no fault.
- Illegal opcode 0000000: DECODE leads to FAULT, INSTRET unchanged, RF_WE/PC_ENA never asserted.
- STORE with RST pulsed low during MEM:
  - MEM_REQ drops in the same cycle; STATE=0, INSTRET=0.
  - After release, FETCH resumes with MEM_REQ=1.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller.
// Holds the state encoding, the base opcodes the controller recognises,
// the datapath mux encodings and the ALU operation codes.
// No ports: this is a package imported by the controller files.
package riscv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd7
  } state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] PC_SEL_PC4 = 2'd0;
  localparam logic [1:0] PC_SEL_IMM = 2'd1;
  localparam logic [1:0] PC_SEL_ALU = 2'd2;

  localparam logic [1:0] A_SEL_RS1  = 2'd0;
  localparam logic [1:0] A_SEL_PC   = 2'd1;
  localparam logic [1:0] A_SEL_ZERO = 2'd2;

  localparam logic [1:0] B_SEL_RS2 = 2'd0;
  localparam logic [1:0] B_SEL_IMM = 2'd1;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MDR = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_SRA = 4'b1101;

endpackage

// File: rtl/riscv_ctrl_fsm_if.sv
// Bundle of the signals exchanged between the control FSM and the datapath.
// master : the controller (reads IR fields / memory status, drives enables,
//          selects, status and the retired-instruction count)
// slave  : the datapath side (drives IR fields / memory status, consumes
//          everything the controller produces)
interface riscv_ctrl_fsm_if #(
  parameter int CNT_W = 32
);

  logic [6:0]       OPCODE;
  logic [2:0]       FUNCT3;
  logic             FUNCT7_5;
  logic             BR_TAKEN;
  logic             MEM_READY;
  logic             PC_ENA;
  logic             IR_ENA;
  logic             MDR_ENA;
  logic             RF_WE;
  logic             MEM_REQ;
  logic             MEM_WE;
  logic [1:0]       PC_SEL;
  logic [1:0]       ALU_A_SEL;
  logic [1:0]       ALU_B_SEL;
  logic [3:0]       ALU_OP;
  logic [1:0]       WB_SEL;
  logic [2:0]       STATE;
  logic             FAULT;
  logic [CNT_W-1:0] INSTRET;

  modport master (
    input  OPCODE, FUNCT3, FUNCT7_5, BR_TAKEN, MEM_READY,
    output PC_ENA, IR_ENA, MDR_ENA, RF_WE, MEM_REQ, MEM_WE,
    output PC_SEL, ALU_A_SEL, ALU_B_SEL, ALU_OP, WB_SEL,
    output STATE, FAULT, INSTRET
  );

  modport slave (
    output OPCODE, FUNCT3, FUNCT7_5, BR_TAKEN, MEM_READY,
    input  PC_ENA, IR_ENA, MDR_ENA, RF_WE, MEM_REQ, MEM_WE,
    input  PC_SEL, ALU_A_SEL, ALU_B_SEL, ALU_OP, WB_SEL,
    input  STATE, FAULT, INSTRET
  );

endinterface

// File: rtl/riscv_alu_decode.sv
// Purely combinational instruction-class decoder.
// Ports:
//   i_opcode   IR[6:0]
//   i_funct3   IR[14:12]
//   i_funct7_5 IR[30]
//   o_alu_op   {f7_5_eff, funct3}
//   o_a_sel    ALU operand A select
//   o_b_sel    ALU operand B select
//   o_legal    opcode is one of the supported RV32I base opcodes
module riscv_alu_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [3:0] o_alu_op,
  output logic [1:0] o_a_sel,
  output logic [1:0] o_b_sel,
  output logic       o_legal
);

  // Default is the address-generation form (rs1 + imm, ADD) used by
  // LOAD/STORE/JALR; other classes override only what differs.
  // Only SRAI/SRLI carry a meaningful funct7 bit among the immediates, so
  // every other OP-IMM funct3 must ignore IR[30] (it is immediate data).
  // Branches compare rs1 against rs2, hence SUB.
  always_comb begin
    o_alu_op = ALU_ADD;
    o_a_sel  = A_SEL_RS1;
    o_b_sel  = B_SEL_IMM;
    o_legal  = 1'b1;
    case (i_opcode)
      OP_RTYPE: begin
        o_b_sel  = B_SEL_RS2;
        o_alu_op = {i_funct7_5, i_funct3};
      end
      OP_IMM: begin
        o_alu_op = {(i_funct3 == 3'b101) ? i_funct7_5 : 1'b0, i_funct3};
      end
      OP_LOAD, OP_STORE, OP_JALR: begin
        o_alu_op = ALU_ADD;
      end
      OP_LUI: begin
        o_a_sel = A_SEL_ZERO;
      end
      OP_AUIPC, OP_JAL: begin
        o_a_sel = A_SEL_PC;
      end
      OP_BRANCH: begin
        o_b_sel  = B_SEL_RS2;
        o_alu_op = ALU_SUB;
      end
      default: begin
        o_b_sel = B_SEL_RS2;
        o_legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle control FSM for the RV32I core. Generates the load enables for
// the PC/IR/MDR registers, register-file write enable, memory request and the
// datapath mux selects; owns the memory-wait watchdog and the INSTRET counter.
// Ports:
//   CLK   rising-edge clock
//   RST   asynchronous active-low reset
//   ctrl  riscv_ctrl_fsm_if.master: IR fields, BR_TAKEN, MEM_READY in;
//         enables, selects, STATE, FAULT, INSTRET out
// Parameters:
//   WAIT_LIMIT  consecutive MEM_READY-low cycles tolerated in FETCH/MEM (>=1)
//   CNT_W       width of INSTRET
module riscv_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 32
)(
  input  logic            CLK,
  input  logic            RST,
  riscv_ctrl_fsm_if.master ctrl
);

  localparam logic [2:0] S_FETCH  = 3'(ST_FETCH);
  localparam logic [2:0] S_DECODE = 3'(ST_DECODE);
  localparam logic [2:0] S_EXEC   = 3'(ST_EXEC);
  localparam logic [2:0] S_MEM    = 3'(ST_MEM);
  localparam logic [2:0] S_WB     = 3'(ST_WB);
  localparam logic [2:0] S_FAULT  = 3'(ST_FAULT);

  localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

  logic [2:0]        r_state;
  logic [WCNT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_instret;

  logic [2:0] w_next;
  logic       w_pc_ena;
  logic       w_ir_ena;
  logic       w_mdr_ena;
  logic       w_rf_we;
  logic       w_mem_req;
  logic       w_mem_we;
  logic [1:0] w_pc_sel;
  logic [1:0] w_a_sel;
  logic [1:0] w_b_sel;
  logic [3:0] w_alu_op;
  logic [1:0] w_wb_sel;

  logic [3:0] w_dec_alu_op;
  logic [1:0] w_dec_a_sel;
  logic [1:0] w_dec_b_sel;
  logic       w_dec_legal;
  logic       w_waiting;
  logic       w_wait_hit;
  logic       w_is_load;
  logic       w_is_store;

  riscv_alu_decode u_alu_decode (
    .i_opcode   (ctrl.OPCODE),
    .i_funct3   (ctrl.FUNCT3),
    .i_funct7_5 (ctrl.FUNCT7_5),
    .o_alu_op   (w_dec_alu_op),
    .o_a_sel    (w_dec_a_sel),
    .o_b_sel    (w_dec_b_sel),
    .o_legal    (w_dec_legal)
  );

  assign w_is_load  = (ctrl.OPCODE == OP_LOAD);
  assign w_is_store = (ctrl.OPCODE == OP_STORE);

  // A memory-wait cycle is any FETCH/MEM cycle where memory has not answered;
  // the limit cycle only faults if memory is still silent in it.
  assign w_waiting  = ((r_state == S_FETCH) || (r_state == S_MEM)) && !ctrl.MEM_READY;
  assign w_wait_hit = w_waiting && (r_wait == WCNT_W'(WAIT_LIMIT - 1));

  // Next-state and control decode. ALU selects track the decoded instruction
  // through EXEC/MEM/WB so the ALU result is stable until write-back.
  always_comb begin
    w_next    = r_state;
    w_pc_ena  = 1'b0;
    w_ir_ena  = 1'b0;
    w_mdr_ena = 1'b0;
    w_rf_we   = 1'b0;
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_pc_sel  = PC_SEL_PC4;
    w_a_sel   = A_SEL_RS1;
    w_b_sel   = B_SEL_RS2;
    w_alu_op  = ALU_ADD;
    w_wb_sel  = WB_SEL_ALU;

    if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
      w_a_sel  = w_dec_a_sel;
      w_b_sel  = w_dec_b_sel;
      w_alu_op = w_dec_alu_op;
    end

    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (ctrl.MEM_READY) begin
          w_ir_ena = 1'b1;
          w_next   = S_DECODE;
        end else if (w_wait_hit) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        w_next = w_dec_legal ? S_EXEC : S_FAULT;
      end
      S_EXEC: begin
        if (ctrl.OPCODE == OP_BRANCH) begin
          w_pc_ena = 1'b1;
          w_pc_sel = ctrl.BR_TAKEN ? PC_SEL_IMM : PC_SEL_PC4;
          w_next   = S_FETCH;
        end else if (w_is_load || w_is_store) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = w_is_store;
        if (ctrl.MEM_READY) begin
          if (w_is_load) begin
            w_mdr_ena = 1'b1;
            w_next    = S_WB;
          end else begin
            w_pc_ena = 1'b1;
            w_next   = S_FETCH;
          end
        end else if (w_wait_hit) begin
          w_next = S_FAULT;
        end
      end
      S_WB: begin
        w_rf_we  = 1'b1;
        w_pc_ena = 1'b1;
        w_next   = S_FETCH;
        if (w_is_load) begin
          w_wb_sel = WB_SEL_MDR;
        end else if ((ctrl.OPCODE == OP_JAL) || (ctrl.OPCODE == OP_JALR)) begin
          w_wb_sel = WB_SEL_PC4;
        end
        if (ctrl.OPCODE == OP_JAL) begin
          w_pc_sel = PC_SEL_IMM;
        end else if (ctrl.OPCODE == OP_JALR) begin
          w_pc_sel = PC_SEL_ALU;
        end
      end
      S_FAULT: begin
        w_next = S_FAULT;
      end
      default: begin
        w_next = S_FAULT;
      end
    endcase
  end

  // State, watchdog and retirement registers. The wait counter is zero on
  // every non-waiting cycle, which also makes it start from zero on each
  // entry to FETCH or MEM.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_waiting && !w_wait_hit) begin
        r_wait <= r_wait + WCNT_W'(1);
      end else begin
        r_wait <= '0;
      end
      if (w_pc_ena) begin
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  // While RST is low every load/request is forced off so no datapath register
  // can capture during reset, independent of the state register.
  assign ctrl.PC_ENA    = RST & w_pc_ena;
  assign ctrl.IR_ENA    = RST & w_ir_ena;
  assign ctrl.MDR_ENA   = RST & w_mdr_ena;
  assign ctrl.RF_WE     = RST & w_rf_we;
  assign ctrl.MEM_REQ   = RST & w_mem_req;
  assign ctrl.MEM_WE    = RST & w_mem_we;
  assign ctrl.PC_SEL    = {2{RST}} & w_pc_sel;
  assign ctrl.ALU_A_SEL = {2{RST}} & w_a_sel;
  assign ctrl.ALU_B_SEL = {2{RST}} & w_b_sel;
  assign ctrl.ALU_OP    = {4{RST}} & w_alu_op;
  assign ctrl.WB_SEL    = {2{RST}} & w_wb_sel;
  assign ctrl.STATE     = r_state;
  assign ctrl.FAULT     = (r_state == S_FAULT);
  assign ctrl.INSTRET   = r_instret;

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Self-checking bench for riscv_ctrl_fsm. Each stimulus cycle pushes the
// hand-computed expected output snapshot into a scoreboard queue; a monitor
// pops and compares one snapshot per cycle on the falling clock edge.
module tb_riscv_ctrl_fsm;

  typedef struct {
    string       name;
    logic [2:0]  state;
    logic [5:0]  ena;
    logic [1:0]  pcSel;
    logic [1:0]  aSel;
    logic [1:0]  bSel;
    logic [3:0]  aluOp;
    logic [1:0]  wbSel;
    logic        fault;
    logic [31:0] instret;
    bit          careAlu;
  } expect_t;

  // Enable patterns packed as {PC, IR, MDR, RF_WE, MEM_REQ, MEM_WE}
  localparam logic [5:0] E_NONE  = 6'b000000;
  localparam logic [5:0] E_FRDY  = 6'b010010;
  localparam logic [5:0] E_REQ   = 6'b000010;
  localparam logic [5:0] E_WB    = 6'b100100;
  localparam logic [5:0] E_PC    = 6'b100000;
  localparam logic [5:0] E_LDRDY = 6'b001010;
  localparam logic [5:0] E_ST    = 6'b000011;
  localparam logic [5:0] E_STRDY = 6'b100011;

  logic CLK;
  logic RST;

  int vectorCount;
  int missCount;
  expect_t scoreQ[$];

  riscv_ctrl_fsm_if #(.CNT_W(32)) ctrlIf ();

  riscv_ctrl_fsm #(
    .WAIT_LIMIT (15),
    .CNT_W      (32)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .ctrl (ctrlIf)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic setInstr(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    ctrlIf.OPCODE   = op;
    ctrlIf.FUNCT3   = f3;
    ctrlIf.FUNCT7_5 = f75;
  endtask

  // Drive one cycle of inputs, queue what the DUT must show in that cycle,
  // then move to just after the next rising edge.
  task automatic applyStimulus(input string name, input logic rst, input logic br,
                               input logic rdy, input logic [2:0] st, input logic [5:0] ena,
                               input logic [1:0] pcSel, input logic [1:0] aSel,
                               input logic [1:0] bSel, input logic [3:0] aluOp,
                               input logic [1:0] wbSel, input logic fault,
                               input logic [31:0] ins, input bit careAlu);
    expect_t e;
    RST              = rst;
    ctrlIf.BR_TAKEN  = br;
    ctrlIf.MEM_READY = rdy;
    e.name    = name;
    e.state   = st;
    e.ena     = ena;
    e.pcSel   = pcSel;
    e.aSel    = aSel;
    e.bSel    = bSel;
    e.aluOp   = aluOp;
    e.wbSel   = wbSel;
    e.fault   = fault;
    e.instret = ins;
    e.careAlu = careAlu;
    scoreQ.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input expect_t e);
    logic [5:0] actEna;
    bit ok;
    actEna = {ctrlIf.PC_ENA, ctrlIf.IR_ENA, ctrlIf.MDR_ENA,
              ctrlIf.RF_WE, ctrlIf.MEM_REQ, ctrlIf.MEM_WE};
    ok = (ctrlIf.STATE === e.state) && (actEna === e.ena) &&
         (ctrlIf.PC_SEL === e.pcSel) && (ctrlIf.WB_SEL === e.wbSel) &&
         (ctrlIf.FAULT === e.fault) && (ctrlIf.INSTRET === e.instret);
    if (e.careAlu) begin
      ok = ok && (ctrlIf.ALU_A_SEL === e.aSel) && (ctrlIf.ALU_B_SEL === e.bSel) &&
           (ctrlIf.ALU_OP === e.aluOp);
    end
    vectorCount++;
    if (!ok) begin
      missCount++;
      $display("[TB] FAIL %s: got st=%0d ena=%b pc=%0d a=%0d b=%0d op=%b wb=%0d flt=%b ret=%0d; want st=%0d ena=%b pc=%0d a=%0d b=%0d op=%b wb=%0d flt=%b ret=%0d (alu %0d)",
               e.name, ctrlIf.STATE, actEna, ctrlIf.PC_SEL, ctrlIf.ALU_A_SEL,
               ctrlIf.ALU_B_SEL, ctrlIf.ALU_OP, ctrlIf.WB_SEL, ctrlIf.FAULT,
               ctrlIf.INSTRET, e.state, e.ena, e.pcSel, e.aSel, e.bSel, e.aluOp,
               e.wbSel, e.fault, e.instret, e.careAlu);
    end
  endtask

  // Monitor: one snapshot per cycle, sampled mid-cycle on the falling edge.
  initial begin
    expect_t e;
    forever begin
      @(negedge CLK);
      if (scoreQ.size() > 0) begin
        e = scoreQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    vectorCount = 0;
    missCount   = 0;
    RST = 1'b0;
    ctrlIf.BR_TAKEN  = 1'b0;
    ctrlIf.MEM_READY = 1'b0;
    setInstr(7'b0000000, 3'b000, 1'b0);
    @(posedge CLK);
    #1;

    applyStimulus("reset", 0, 0, 1, 3'd0, E_NONE, 0, 0, 0, 4'b0000, 0, 0, 0, 1);

    // SUB: R-type, funct7_5 selects subtract
    setInstr(7'b0110011, 3'b000, 1'b1);
    applyStimulus("sub_fetch",  1, 0, 1, 3'd0, E_FRDY, 0, 0, 0, 4'b0000, 0, 0, 0, 1);
    applyStimulus("sub_decode", 1, 0, 1, 3'd1, E_NONE, 0, 0, 0, 4'b0000, 0, 0, 0, 1);
    applyStimulus("sub_exec",   1, 0, 1, 3'd2, E_NONE, 0, 0, 0, 4'b1000, 0, 0, 0, 1);
    applyStimulus("sub_wb",     1, 0, 1, 3'd4, E_WB,   0, 0, 0, 4'b1000, 0, 0, 0, 1);

    // LOAD with three stalled MEM cycles
    setInstr(7'b0000011, 3'b010, 1'b0);
    applyStimulus("ld_fetch",  1, 0, 1, 3'd0, E_FRDY, 0, 0, 0, 4'b0000, 0, 0, 1, 1);
    applyStimulus("ld_decode", 1, 0, 1, 3'd1, E_NONE, 0, 0, 0, 4'b0000, 0, 0, 1, 1);
    applyStimulus("ld_exec",   1, 0, 1, 3'd2, E_NONE, 0, 0, 1, 4'b0000, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("ld_mem_wait", 1, 0, 0, 3'd3, E_REQ, 0, 0, 1, 4'b0000, 0, 0, 1, 1);
    end
    applyStimulus("ld_mem_rdy", 1, 0, 1, 3'd3, E_LDRDY, 0, 0, 1, 4'b0000, 0, 0, 1, 1);
    applyStimulus("ld_wb",      1, 0, 1, 3'd4, E_WB,    0, 0, 1, 4'b0000, 1, 0, 1, 1);

    // BEQ taken then not taken; retires in EXEC
    setInstr(7'b1100011, 3'b000, 1'b0);
    applyStimulus("beqt_fetch",  1, 0, 1, 3'd0, E_FRDY, 0, 0, 0, 4'b0000, 0, 0, 2, 1);
    applyStimulus("beqt_decode", 1, 0, 1, 3'd1, E_NONE, 0, 0, 0, 4'b0000, 0, 0, 2, 1);
    applyStimulus("beqt_exec",   1, 1, 1, 3'd2, E_PC,   1, 0, 0, 4'b0000, 0, 0, 2, 0);
    applyStimulus("beqn_fetch",  1, 0, 1, 3'd0, E_FRDY, 0, 0, 0, 4'b0000, 0, 0, 3, 1);
    applyStimulus("beqn_decode", 1, 0, 1, 3'd1, E_NONE, 0, 0, 0, 4'b0000, 0, 0, 3, 1);
    applyStimulus("beqn_exec",   1, 0, 1, 3'd2, E_PC,   0, 0, 0, 4'b0000, 0, 0, 3, 0);

    // JAL: link via PC+4, target PC+imm
    setInstr(7'b1101111, 3'b000, 1'b0);
    applyStimulus("jal_fetch",  1, 0, 1, 3'd0, E_FRDY, 0, 0, 0, 4'b0000, 0, 0, 4, 1);
    applyStimulus("jal_decode", 1, 0, 1, 3'd1, E_NONE, 0, 0, 0, 4'b0000, 0, 0, 4, 1);
    applyStimulus("jal_exec",   1, 0, 1, 3'd2, E_NONE, 0, 0, 0, 4'b0000, 0, 0, 4, 0);
    applyStimulus("jal_wb",     1, 0, 1, 3'd4, E_WB,   1, 0, 0, 4'b0000, 2, 0, 4, 0);

    // SRAI: funct7_5 honoured for funct3=101
    setInstr(7'b0010011, 3'b101, 1'b1);
    applyStimulus("srai_fetch",  1, 0, 1, 3'd0, E_FRDY, 0, 0, 0, 4'b0000, 0, 0, 5, 1);
    applyStimulus("srai_decode", 1, 0, 1, 3'd1, E_NONE, 0, 0, 0, 4'b0000, 0, 0, 5, 1);
    applyStimulus("srai_exec",   1, 0, 1, 3'd2, E_NONE, 0, 0, 1, 4'b1101, 0, 0, 5, 1);
    applyStimulus("srai_wb",     1, 0, 1, 3'd4, E_WB,   0, 0, 1, 4'b1101, 0, 0, 5, 1);

    // ADDI with IR[30] set: must stay ADD
    setInstr(7'b0010011, 3'b000, 1'b1);
    applyStimulus("addi_fetch",  1, 0, 1, 3'd0, E_FRDY, 0, 0, 0, 4'b0000, 0, 0, 6, 1);
    applyStimulus("addi_decode", 1, 0, 1, 3'd1, E_NONE, 0, 0, 0, 4'b0000, 0, 0, 6, 1);
    applyStimulus("addi_exec",   1, 0, 1, 3'd2, E_NONE, 0, 0, 1, 4'b0000, 0, 0, 6, 1);
    applyStimulus("addi_wb",     1, 0, 1, 3'd4, E_WB,   0, 0, 1, 4'b0000, 0, 0, 6, 1);

    // STORE retiring from MEM
    setInstr(7'b0100011, 3'b010, 1'b0);
    applyStimulus("st_fetch",  1, 0, 1, 3'd0, E_FRDY,  0, 0, 0, 4'b0000, 0, 0, 7, 1);
    applyStimulus("st_decode", 1, 0, 1, 3'd1, E_NONE,  0, 0, 0, 4'b0000, 0, 0, 7, 1);
    applyStimulus("st_exec",   1, 0, 1, 3'd2, E_NONE,  0, 0, 1, 4'b0000, 0, 0, 7, 1);
    applyStimulus("st_mem",    1, 0, 1, 3'd3, E_STRDY, 0, 0, 1, 4'b0000, 0, 0, 7, 1);

    // STORE abandoned by a reset pulse during MEM
    applyStimulus("st2_fetch",  1, 0, 1, 3'd0, E_FRDY, 0, 0, 0, 4'b0000, 0, 0, 8, 1);
    applyStimulus("st2_decode", 1, 0, 1, 3'd1, E_NONE, 0, 0, 0, 4'b0000, 0, 0, 8, 1);
    applyStimulus("st2_exec",   1, 0, 1, 3'd2, E_NONE, 0, 0, 1, 4'b0000, 0, 0, 8, 1);
    applyStimulus("st2_mem",    1, 0, 0, 3'd3, E_ST,   0, 0, 1, 4'b0000, 0, 0, 8, 1);
    applyStimulus("st2_rst",    0, 0, 0, 3'd0, E_NONE, 0, 0, 0, 4'b0000, 0, 0, 0, 1);
    applyStimulus("st2_resume", 1, 0, 0, 3'd0, E_REQ,  0, 0, 0, 4'b0000, 0, 0, 0, 1);

    // Watchdog: wait cycles 2..14, then MEM_READY in the limit cycle wins
    for (int i = 0; i < 13; i++) begin
      applyStimulus("wd_wait", 1, 0, 0, 3'd0, E_REQ, 0, 0, 0, 4'b0000, 0, 0, 0, 1);
    end
    setInstr(7'b0000000, 3'b000, 1'b0);
    applyStimulus("wd_limit_rdy", 1, 0, 1, 3'd0, E_FRDY, 0, 0, 0, 4'b0000, 0, 0, 0, 1);

    // Illegal opcode faults from DECODE and stays there
    applyStimulus("ill_decode", 1, 0, 1, 3'd1, E_NONE, 0, 0, 0, 4'b0000, 0, 0, 0, 1);
    applyStimulus("ill_fault",  1, 0, 1, 3'd7, E_NONE, 0, 0, 0, 4'b0000, 0, 1, 0, 1);
    applyStimulus("ill_hold",   1, 1, 1, 3'd7, E_NONE, 0, 0, 0, 4'b0000, 0, 1, 0, 1);

    // Only reset leaves FAULT; then 15 silent FETCH cycles trip the watchdog
    setInstr(7'b0110011, 3'b000, 1'b0);
    applyStimulus("flt_rst", 0, 0, 0, 3'd0, E_NONE, 0, 0, 0, 4'b0000, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      applyStimulus("wd_silent", 1, 0, 0, 3'd0, E_REQ, 0, 0, 0, 4'b0000, 0, 0, 0, 1);
    end
    applyStimulus("wd_fault", 1, 0, 1, 3'd7, E_NONE, 0, 0, 0, 4'b0000, 0, 1, 0, 1);
    applyStimulus("wd_hold",  1, 0, 1, 3'd7, E_NONE, 0, 0, 0, 4'b0000, 0, 1, 0, 1);

    for (int i = 0; i < 20 && scoreQ.size() > 0; i++) begin
      @(negedge CLK);
    end
    if (scoreQ.size() > 0) begin
      missCount++;
      $display("[TB] FAIL drain: %0d snapshots left unchecked, required 0", scoreQ.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
